hsv_threshold_bank: RTL and testbench
=====================================

// Module: hsv_threshold_bank
// PURPOSE
//  Parametrised N-object HSV threshold register bank for AirPong object tracking. Holds H1/H2/S/V min/max per object.
//  User buttons calibrate the selected object around its sampled centre HSV, or nudge one min/max field.
//  Hue calibration wraps around 0/255 using the H1/H2 interval pair. Outputs feed the per-object HSV pixel masks.
// PARAMETERS
//  NUM_OBJ      3   number of tracked objects (puck, paddle1, paddle2, ...); 1..15
//  OBJ_W        2   width of obj_sel; 2**OBJ_W >= NUM_OBJ
//  INIT_THRESH  25  half-width applied on calibrate (+/- around centre)
//  STEP         3   increment/decrement per adjust event
//  HOLD_CYC     24  cycles a button is held before auto-repeat (macro-gated)
//  REPEAT_CYC   8   cycles between auto-repeat events (macro-gated)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            synchronous, active-high
//  obj_sel      in   OBJ_W        object to calibrate/adjust
//  field_sel    in   2            0:H1 1:H2 2:S 3:V, target of adjust buttons
//  enable       in   1            1 = buttons act; 0 = all button actions ignored
//  btn_enter    in   1            calibrate level input (debounced)
//  btn_min_dec  in   1            min -= STEP (level)
//  btn_min_inc  in   1            min += STEP (level)
//  btn_max_dec  in   1            max -= STEP (level)
//  btn_max_inc  in   1            max += STEP (level)
//  center_hsv   in   NUM_OBJ*24   per object {h,s,v} centre sample, obj k at [24k+:24]
//  thresh       out  NUM_OBJ*64   per object {h1_min,h1_max,h2_min,h2_max,s_min,s_max,v_min,v_max}, obj k at [64k+:64]
//  update       out  1            1-cycle pulse, coincident with any thresh change
// BEHAVIOUR
//  Reset: every min = 8'd0, every max = 8'd255, update = 0, edge/repeat state cleared. Reset mid-hold aborts the repeat.
//  Edge detect: each button registered once; event = level & ~prev. Press first sampled high at edge n -> thresh/update
//   change at edge n+1 (update visible one cycle after sample). Registers are written only on an event.
//  One action per cycle; priority enter > min_dec > min_inc > max_dec > max_inc; lower-priority events that cycle dropped.
//  Ignored (no write, no update): enable=0, or obj_sel >= NUM_OBJ.
//  Calibrate (enter), centre h,s,v of obj_sel, T = INIT_THRESH, all arithmetic 9-bit:
//   h-T<0:      H1=[0,h+T]       H2=[256+h-T,255]
//   h+T>255:    H1=[h-T,255]     H2=[0,h+T-256]
//   otherwise:  H1=[h-T,h+T]     H2=H1
//   S=[max(s-T,0),min(s+T,255)]; V likewise. Other objects untouched.
//  Adjust on field_sel of obj_sel, saturating, min never crosses max:
//   min_inc: min=min(min+STEP,max)   min_dec: min=max(min-STEP,0)
//   max_inc: max=min(max+STEP,255)   max_dec: max=max(max-STEP,min)
//   update pulses even when saturation leaves the value unchanged.
//  obj_sel/field_sel sampled on the event cycle; changing them mid-hold retargets later repeat events.
// CONFIGURATION
//  HSV_THRESH_AUTOREPEAT_EN defined: one repeat FSM over the four adjust buttons (enter never repeats).
//   IDLE -(adjust event)-> HOLD, cnt=0; HOLD: cnt++, all adjust buttons released -> IDLE, cnt==HOLD_CYC-1 -> REPEAT,
//   emit event, cnt=0; REPEAT: cnt++, release -> IDLE, cnt==REPEAT_CYC-1 -> emit event, cnt=0.
//   Repeat event uses the highest-priority adjust button currently held. Counter width $clog2(max(HOLD_CYC,REPEAT_CYC)+1).
//  Not defined: no FSM/counters; exactly one action per press regardless of hold time.
// TESTING
//  Reset, then read all objs -> mins 0, maxes 255, update 0.
//  obj_sel=1, centre h=100 s=10 v=250, enter pulse -> obj1 H1=H2=[75,125], S=[0,35], V=[225,255]; objs 0,2 unchanged; 1 update.
//  obj 0 centre h=10, enter -> H1=[0,35], H2=[241,255]; h=240 -> H1=[215,255], H2=[0,9].
//  V=[225,255], field_sel=3: max_inc -> 255 + update; min_inc x11 -> min stops at 255; max_dec -> 255 (= min).
//  Same-cycle enter+min_inc -> calibrate only; enable=0 or obj_sel=3 with NUM_OBJ=3 -> no change, no update.
//  AUTOREPEAT_EN, HOLD_CYC=24, REPEAT_CYC=8: hold min_dec 60 cycles -> events at cycles 1, 25, 33, 41, 49, 57 of hold; reset at 40 -> stops.

Source files
------------

// File: rtl/hsv_threshold_bank_if.sv
// Interface for hsv_threshold_bank: the button and selection inputs, the per-object
// centre samples, the packed per-object threshold vector, and the update strobe.
interface hsv_threshold_bank_if #(
  parameter int NUM_OBJ = 3,
  parameter int OBJ_W   = 2
);
  logic [OBJ_W-1:0]      obj_sel;
  logic [1:0]            field_sel;
  logic                  enable;
  logic                  btn_enter;
  logic                  btn_min_dec;
  logic                  btn_min_inc;
  logic                  btn_max_dec;
  logic                  btn_max_inc;
  logic [NUM_OBJ*24-1:0] center_hsv;
  logic [NUM_OBJ*64-1:0] thresh;
  logic                  update;

  modport master (
    output obj_sel, field_sel, enable,
    output btn_enter, btn_min_dec, btn_min_inc, btn_max_dec, btn_max_inc,
    output center_hsv,
    input  thresh, update
  );

  modport slave (
    input  obj_sel, field_sel, enable,
    input  btn_enter, btn_min_dec, btn_min_inc, btn_max_dec, btn_max_inc,
    input  center_hsv,
    output thresh, update
  );
endinterface

// File: rtl/hsv_threshold_bank.sv
// N-object HSV threshold register bank with button calibrate/adjust for object tracking.
// Define HSV_THRESH_AUTOREPEAT_EN to add hold-to-repeat on the four adjust buttons.
module hsv_threshold_bank #(
  parameter int NUM_OBJ     = 3,
  parameter int OBJ_W       = 2,
  parameter int INIT_THRESH = 25,
  parameter int STEP        = 3,
  parameter int HOLD_CYC    = 24,
  parameter int REPEAT_CYC  = 8
) (
  input logic                 clk,
  input logic                 reset,
  hsv_threshold_bank_if.slave bus
);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CAL,
    ACT_MIN_DEC,
    ACT_MIN_INC,
    ACT_MAX_DEC,
    ACT_MAX_INC
  } act_t;

  localparam logic [8:0] THR = 9'(INIT_THRESH);
  localparam logic [8:0] STP = 9'(STEP);

  // Button vectors, bit order is also priority order: enter, min_dec, min_inc, max_dec, max_inc
  logic [4:0]  btn_q;
  logic [4:0]  btn_prev;
  logic [4:0]  edge_ev;
  logic [4:0]  rep_ev;
  logic [4:0]  ev;

  logic [7:0]  mn [NUM_OBJ][4];
  logic [7:0]  mx [NUM_OBJ][4];
  logic [7:0]  cur_mn [4];
  logic [7:0]  cur_mx [4];
  logic [7:0]  nxt_mn [4];
  logic [7:0]  nxt_mx [4];
  logic [23:0] cur_c;

  logic        sel_ok;
  act_t        act;
  logic        upd_q;

  logic [8:0]  h9;
  logic [8:0]  h_lo;
  logic [8:0]  h_hi;
  logic [15:0] s_band;
  logic [15:0] v_band;
  logic [8:0]  mn9;
  logic [8:0]  mx9;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q    <= '0;
      btn_prev <= '0;
    end else begin
      btn_q    <= {bus.btn_max_inc, bus.btn_max_dec, bus.btn_min_inc,
                   bus.btn_min_dec, bus.btn_enter};
      btn_prev <= btn_q;
    end
  end

  assign edge_ev = btn_q & ~btn_prev;
  assign ev      = edge_ev | rep_ev;
  assign sel_ok  = bus.enable && (int'(bus.obj_sel) < NUM_OBJ);

  always_comb begin
    act = ACT_NONE;
    if (sel_ok) begin
      if      (ev[0]) act = ACT_CAL;
      else if (ev[1]) act = ACT_MIN_DEC;
      else if (ev[2]) act = ACT_MIN_INC;
      else if (ev[3]) act = ACT_MAX_DEC;
      else if (ev[4]) act = ACT_MAX_INC;
    end
  end

  always_comb begin
    for (int unsigned f = 0; f < 4; f++) begin
      cur_mn[f] = '0;
      cur_mx[f] = '0;
    end
    cur_c = '0;
    for (int unsigned k = 0; k < NUM_OBJ; k++) begin
      if (bus.obj_sel == OBJ_W'(k)) begin
        for (int unsigned f = 0; f < 4; f++) begin
          cur_mn[f] = mn[k][f];
          cur_mx[f] = mx[k][f];
        end
        cur_c = bus.center_hsv[24*k +: 24];
      end
    end
  end

  // Saturating {lo, hi} band of +/-THR around a centre value
  function automatic logic [15:0] band(input logic [7:0] c);
    logic [8:0] c9;
    logic [8:0] hi9;
    logic [7:0] lo;
    logic [7:0] hi;
    c9  = {1'b0, c};
    hi9 = c9 + THR;
    lo  = (c9 < THR) ? 8'd0 : 8'(c9 - THR);
    hi  = (hi9 > 9'd255) ? 8'd255 : hi9[7:0];
    return {lo, hi};
  endfunction

  always_comb begin
    h9     = {1'b0, cur_c[23:16]};
    h_lo   = h9 - THR;
    h_hi   = h9 + THR;
    s_band = band(cur_c[15:8]);
    v_band = band(cur_c[7:0]);
    mn9    = {1'b0, cur_mn[bus.field_sel]};
    mx9    = {1'b0, cur_mx[bus.field_sel]};

    for (int unsigned f = 0; f < 4; f++) begin
      nxt_mn[f] = cur_mn[f];
      nxt_mx[f] = cur_mx[f];
    end

    unique case (act)
      ACT_CAL: begin
        // The low 8 bits of a wrapped 9-bit sum give the hue on the far side of 0/255
        if (h9 < THR) begin
          nxt_mn[0] = 8'd0;
          nxt_mx[0] = h_hi[7:0];
          nxt_mn[1] = h_lo[7:0];
          nxt_mx[1] = 8'd255;
        end else if (h_hi > 9'd255) begin
          nxt_mn[0] = h_lo[7:0];
          nxt_mx[0] = 8'd255;
          nxt_mn[1] = 8'd0;
          nxt_mx[1] = h_hi[7:0];
        end else begin
          nxt_mn[0] = h_lo[7:0];
          nxt_mx[0] = h_hi[7:0];
          nxt_mn[1] = h_lo[7:0];
          nxt_mx[1] = h_hi[7:0];
        end
        nxt_mn[2] = s_band[15:8];
        nxt_mx[2] = s_band[7:0];
        nxt_mn[3] = v_band[15:8];
        nxt_mx[3] = v_band[7:0];
      end
      ACT_MIN_DEC:
        nxt_mn[bus.field_sel] = (mn9 < STP) ? 8'd0 : 8'(mn9 - STP);
      ACT_MIN_INC:
        nxt_mn[bus.field_sel] = (mn9 + STP > mx9) ? mx9[7:0] : 8'(mn9 + STP);
      ACT_MAX_DEC:
        nxt_mx[bus.field_sel] = (mx9 < mn9 + STP) ? mn9[7:0] : 8'(mx9 - STP);
      ACT_MAX_INC:
        nxt_mx[bus.field_sel] = (mx9 + STP > 9'd255) ? 8'd255 : 8'(mx9 + STP);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_OBJ; k++) begin
        for (int unsigned f = 0; f < 4; f++) begin
          mn[k][f] <= '0;
          mx[k][f] <= '1;
        end
      end
      upd_q <= 1'b0;
    end else begin
      upd_q <= (act != ACT_NONE);
      if (act != ACT_NONE) begin
        for (int unsigned k = 0; k < NUM_OBJ; k++) begin
          if (bus.obj_sel == OBJ_W'(k)) begin
            for (int unsigned f = 0; f < 4; f++) begin
              mn[k][f] <= nxt_mn[f];
              mx[k][f] <= nxt_mx[f];
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.thresh = '0;
    for (int unsigned k = 0; k < NUM_OBJ; k++) begin
      for (int unsigned f = 0; f < 4; f++) begin
        bus.thresh[64*k + 56 - 16*f +: 8] = mn[k][f];
        bus.thresh[64*k + 48 - 16*f +: 8] = mx[k][f];
      end
    end
  end

  assign bus.update = upd_q;

`ifdef HSV_THRESH_AUTOREPEAT_EN
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_t;

  rpt_t             rpt_state;
  rpt_t             rpt_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             fire;
  logic             held;

  assign held = |btn_q[4:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_state <= RPT_IDLE;
      cnt       <= '0;
    end else begin
      rpt_state <= rpt_next;
      cnt       <= cnt_next;
    end
  end

  always_comb begin
    rpt_next = rpt_state;
    cnt_next = cnt;
    fire     = 1'b0;
    unique case (rpt_state)
      RPT_IDLE: begin
        if (|edge_ev[4:1]) begin
          rpt_next = RPT_HOLD;
          cnt_next = '0;
        end
      end
      RPT_HOLD: begin
        if (!held) begin
          rpt_next = RPT_IDLE;
          cnt_next = '0;
        end else if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          rpt_next = RPT_REPEAT;
          fire     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (!held) begin
          rpt_next = RPT_IDLE;
          cnt_next = '0;
        end else if (cnt == CNT_W'(REPEAT_CYC - 1)) begin
          fire     = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: rpt_next = RPT_IDLE;
    endcase
  end

  // A repeat acts on whichever adjust button of highest priority is still held
  always_comb begin
    rep_ev = '0;
    if (fire) begin
      if      (btn_q[1]) rep_ev[1] = 1'b1;
      else if (btn_q[2]) rep_ev[2] = 1'b1;
      else if (btn_q[3]) rep_ev[3] = 1'b1;
      else if (btn_q[4]) rep_ev[4] = 1'b1;
    end
  end
`else
  assign rep_ev = '0;
`endif

endmodule

// File: tb/tb_hsv_threshold_bank.sv
// Self-checking bench for hsv_threshold_bank: directed vector table, random presses
// against an arithmetic reference model, and hold/auto-repeat sequences.
module tb_hsv_threshold_bank;
  localparam int NUM_OBJ    = 3;
  localparam int OBJ_W      = 2;
  localparam int T          = 25;
  localparam int STEP       = 3;
  localparam int HOLD_CYC   = 24;
  localparam int REPEAT_CYC = 8;
  localparam int TW         = NUM_OBJ * 64;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_ENT  = 5'b00001;
  localparam logic [4:0] B_MND  = 5'b00010;
  localparam logic [4:0] B_MNI  = 5'b00100;
  localparam logic [4:0] B_MXD  = 5'b01000;
  localparam logic [4:0] B_MXI  = 5'b10000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hsv_threshold_bank_if #(.NUM_OBJ(NUM_OBJ), .OBJ_W(OBJ_W)) bus ();

  hsv_threshold_bank #(
    .NUM_OBJ(NUM_OBJ), .OBJ_W(OBJ_W), .INIT_THRESH(T), .STEP(STEP),
    .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int m_min [NUM_OBJ][4];
  int m_max [NUM_OBJ][4];
  int cen_h [NUM_OBJ];
  int cen_s [NUM_OBJ];
  int cen_v [NUM_OBJ];

  typedef struct {
    logic [4:0] btn;
    int obj; int fsel; bit en;
    int h; int s; int v;
    int cobj; int cfld; int emin; int emax; bit eupd;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic void m_reset();
    for (int k = 0; k < NUM_OBJ; k++)
      for (int f = 0; f < 4; f++) begin
        m_min[k][f] = 0;
        m_max[k][f] = 255;
      end
  endfunction

  function automatic logic [TW-1:0] m_pack();
    logic [TW-1:0] p = '0;
    for (int k = 0; k < NUM_OBJ; k++)
      p[64*k +: 64] = {8'(m_min[k][0]), 8'(m_max[k][0]), 8'(m_min[k][1]), 8'(m_max[k][1]),
                       8'(m_min[k][2]), 8'(m_max[k][2]), 8'(m_min[k][3]), 8'(m_max[k][3])};
    return p;
  endfunction

  // Applies one press to the model; returns whether an update is expected
  function automatic bit m_press(logic [4:0] b, int o, int f, bit en);
    int a = -1;
    int h, s, v;
    if (!en || o >= NUM_OBJ || b == 5'b0) return 1'b0;
    for (int i = 4; i >= 0; i--) if (b[i]) a = i;
    h = cen_h[o]; s = cen_s[o]; v = cen_v[o];
    case (a)
      0: begin
        if (h - T < 0) begin
          m_min[o][0] = 0;           m_max[o][0] = h + T;
          m_min[o][1] = 256 + h - T; m_max[o][1] = 255;
        end else if (h + T > 255) begin
          m_min[o][0] = h - T;       m_max[o][0] = 255;
          m_min[o][1] = 0;           m_max[o][1] = h + T - 256;
        end else begin
          m_min[o][0] = h - T;       m_max[o][0] = h + T;
          m_min[o][1] = h - T;       m_max[o][1] = h + T;
        end
        m_min[o][2] = imax(s - T, 0); m_max[o][2] = imin(s + T, 255);
        m_min[o][3] = imax(v - T, 0); m_max[o][3] = imin(v + T, 255);
      end
      1: m_min[o][f] = imax(m_min[o][f] - STEP, 0);
      2: m_min[o][f] = imin(m_min[o][f] + STEP, m_max[o][f]);
      3: m_max[o][f] = imax(m_max[o][f] - STEP, m_min[o][f]);
      default: m_max[o][f] = imin(m_max[o][f] + STEP, 255);
    endcase
    return 1'b1;
  endfunction

  function automatic vec_t mk(logic [4:0] b, int o, int f, bit en, int h, int s, int v,
                              int co, int cf, int emn, int emx, bit eu);
    vec_t r;
    r.btn = b; r.obj = o; r.fsel = f; r.en = en; r.h = h; r.s = s; r.v = v;
    r.cobj = co; r.cfld = cf; r.emin = emn; r.emax = emx; r.eupd = eu;
    return r;
  endfunction

  task automatic set_btn(input logic [4:0] b);
    bus.btn_enter   = b[0];
    bus.btn_min_dec = b[1];
    bus.btn_min_inc = b[2];
    bus.btn_max_dec = b[3];
    bus.btn_max_inc = b[4];
  endtask

  task automatic drive_center();
    for (int k = 0; k < NUM_OBJ; k++)
      bus.center_hsv[24*k +: 24] = {8'(cen_h[k]), 8'(cen_s[k]), 8'(cen_v[k])};
  endtask

  // One-cycle press; u1 is update after the write edge, u2 one cycle later
  task automatic press(input logic [4:0] b, input int o, input int f, input bit en,
                       output logic u1, output logic u2);
    @(negedge clk);
    bus.obj_sel   = OBJ_W'(o);
    bus.field_sel = 2'(f);
    bus.enable    = en;
    drive_center();
    set_btn(b);
    @(negedge clk);
    set_btn(B_NONE);
    @(posedge clk); #1 u1 = bus.update;
    @(posedge clk); #1 u2 = bus.update;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_btn(B_NONE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  // Holds min_dec for nhold cycles; reset is asserted at hold cycle rst_at
  task automatic hold_test(input int o, input int f, input int nhold, input int rst_at);
    bit exp;
    int last = nhold + 1;
    @(negedge clk);
    bus.obj_sel = OBJ_W'(o); bus.field_sel = 2'(f); bus.enable = 1'b1;
    set_btn(B_MND);
    for (int j = 0; j <= 70; j++) begin
      @(posedge clk); #1;
`ifdef HSV_THRESH_AUTOREPEAT_EN
      exp = (j == 1) || (j >= 1 + HOLD_CYC && j <= last && (j - 1 - HOLD_CYC) % REPEAT_CYC == 0);
`else
      exp = (j == 1);
`endif
      exp = exp && (j < rst_at);
      chk($sformatf("hold_upd_j%0d", j), bus.update, exp);
      if (exp) void'(m_press(B_MND, o, f, 1'b1));
      if (j == nhold) set_btn(B_NONE);
      if (j == rst_at - 1) begin
        reset = 1'b1;
        set_btn(B_NONE);
      end
      if (j == rst_at) m_reset();
      if (j == rst_at + 2) reset = 1'b0;
    end
    chk("hold_thresh", bus.thresh, m_pack());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic u1, u2;
    logic [TW-1:0] th;
    bit eu;

    reset = 1'b1;
    bus.obj_sel = '0; bus.field_sel = '0; bus.enable = 1'b0; bus.center_hsv = '0;
    set_btn(B_NONE);
    for (int k = 0; k < NUM_OBJ; k++) begin cen_h[k] = 0; cen_s[k] = 0; cen_v[k] = 0; end
    do_reset();
    @(posedge clk); #1;
    chk("reset_thresh", bus.thresh, m_pack());
    chk("reset_update", bus.update, 1'b0);

    vt.push_back(mk(B_ENT,  1, 0, 1, 100, 10, 250, 1, 0, 75, 125, 1));
    vt.push_back(mk(B_NONE, 1, 0, 1, 100, 10, 250, 1, 1, 75, 125, 0));
    vt.push_back(mk(B_NONE, 1, 0, 1, 100, 10, 250, 1, 2, 0, 35, 0));
    vt.push_back(mk(B_NONE, 1, 0, 1, 100, 10, 250, 1, 3, 225, 255, 0));
    vt.push_back(mk(B_NONE, 1, 0, 1, 100, 10, 250, 0, 0, 0, 255, 0));
    vt.push_back(mk(B_NONE, 1, 0, 1, 100, 10, 250, 2, 3, 0, 255, 0));
    vt.push_back(mk(B_ENT,  0, 0, 1, 10, 128, 128, 0, 0, 0, 35, 1));
    vt.push_back(mk(B_NONE, 0, 0, 1, 10, 128, 128, 0, 1, 241, 255, 0));
    vt.push_back(mk(B_ENT,  0, 0, 1, 240, 128, 128, 0, 0, 215, 255, 1));
    vt.push_back(mk(B_NONE, 0, 0, 1, 240, 128, 128, 0, 1, 0, 9, 0));
    vt.push_back(mk(B_MXI,  1, 3, 1, 100, 10, 250, 1, 3, 225, 255, 1));
    for (int i = 1; i <= 11; i++)
      vt.push_back(mk(B_MNI, 1, 3, 1, 100, 10, 250, 1, 3, imin(225 + 3*i, 255), 255, 1));
    vt.push_back(mk(B_MXD,  1, 3, 1, 100, 10, 250, 1, 3, 255, 255, 1));
    vt.push_back(mk(B_MND,  1, 3, 1, 100, 10, 250, 1, 3, 252, 255, 1));
    vt.push_back(mk(B_ENT | B_MNI, 1, 3, 1, 50, 100, 100, 1, 3, 75, 125, 1));
    vt.push_back(mk(B_ENT,  1, 3, 0, 0, 0, 0, 1, 3, 75, 125, 0));
    vt.push_back(mk(B_ENT,  3, 0, 1, 0, 0, 0, 2, 0, 0, 255, 0));
    vt.push_back(mk(B_NONE, 0, 0, 1, 240, 128, 128, 0, 0, 215, 255, 0));
    vt.push_back(mk(B_MNI,  0, 0, 1, 240, 128, 128, 0, 0, 218, 255, 1));
    vt.push_back(mk(B_MXD,  2, 2, 1, 60, 60, 60, 2, 2, 0, 252, 1));
    vt.push_back(mk(B_MXI,  2, 2, 1, 60, 60, 60, 2, 2, 0, 255, 1));
    vt.push_back(mk(B_MND,  2, 2, 1, 60, 60, 60, 2, 2, 0, 255, 1));
    vt.push_back(mk(B_MXI,  2, 2, 1, 60, 60, 60, 2, 2, 0, 255, 1));

    foreach (vt[i]) begin
      if (vt[i].obj < NUM_OBJ) begin
        cen_h[vt[i].obj] = vt[i].h; cen_s[vt[i].obj] = vt[i].s; cen_v[vt[i].obj] = vt[i].v;
      end
      press(vt[i].btn, vt[i].obj, vt[i].fsel, vt[i].en, u1, u2);
      th = bus.thresh;
      chk($sformatf("vec%0d_upd", i), u1, vt[i].eupd);
      chk($sformatf("vec%0d_upd_after", i), u2, 1'b0);
      chk($sformatf("vec%0d_field", i), th[64*vt[i].cobj + 48 - 16*vt[i].cfld +: 16],
          {8'(vt[i].emin), 8'(vt[i].emax)});
    end

    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic [4:0] b;
      int o, f;
      bit en;
      for (int k = 0; k < NUM_OBJ; k++) begin
        case ($urandom_range(0, 2))
          0: cen_h[k] = $urandom_range(0, 30);
          1: cen_h[k] = $urandom_range(225, 255);
          default: cen_h[k] = $urandom_range(0, 255);
        endcase
        cen_s[k] = $urandom_range(0, 255);
        cen_v[k] = $urandom_range(0, 255);
      end
      b = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) b[0] = 1'b0;
      o  = $urandom_range(0, 3);
      f  = $urandom_range(0, 3);
      en = ($urandom_range(0, 7) != 0);
      eu = m_press(b, o, f, en);
      press(b, o, f, en, u1, u2);
      chk($sformatf("rnd%0d_upd", n), u1, eu);
      chk($sformatf("rnd%0d_upd_after", n), u2, 1'b0);
      chk($sformatf("rnd%0d_thresh", n), bus.thresh, m_pack());
    end

    do_reset();
    cen_h[2] = 128; cen_s[2] = 200; cen_v[2] = 128;
    eu = m_press(B_ENT, 2, 0, 1'b1);
    press(B_ENT, 2, 0, 1'b1, u1, u2);
    chk("hold_setup_upd", u1, eu);
    hold_test(2, 2, 60, 1000);
    do_reset();
    hold_test(2, 2, 60, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
